// File: rtl/qbus_pkg.sv
// Shared types and default timing for the Qbus DMA master.
package qbus_pkg;

  // Default timing in 100 MHz clocks.
  localparam int T_ASETUP_D  = 15;
  localparam int T_AHOLD_D   = 10;
  localparam int T_DSETUP_D  = 10;
  localparam int T_TIMEOUT_D = 1000;
  localparam int MAX_BURST_D = 4;
  localparam int CNT_W       = 16;

  // Top 9 address bits that select the I/O page (BBS7).
  localparam logic [8:0] IOPAGE_TAG = 9'h1FF;

  typedef enum logic [3:0] {
    S_IDLE, S_REQ, S_ACK, S_ADDR, S_SYNC, S_WDATA, S_RDIN,
    S_RDSK, S_WRPLY, S_NRPLY, S_ENDC, S_RELEASE
  } qbus_state_e;

  // Every registered output of the master, so the FSM can compute
  // the complete next drive set in one place.
  typedef struct packed {
    logic        bdmr;
    logic        bsack;
    logic        bsync;
    logic        bdin;
    logic        bdout;
    logic        bwtbt;
    logic        bbs7;
    logic        bdmgo;
    logic        bdal_oe;
    logic [21:0] bdal;
    logic        rsp_valid;
    logic        rsp_error;
    logic [15:0] rsp_rdata;
  } qbus_drv_t;

  function automatic logic is_iopage(input logic [21:0] a);
    return a[21:13] == IOPAGE_TAG;
  endfunction

endpackage

// File: rtl/qbus_sync.sv
// N-bit two-flop synchronizer for raw bus lines; resets to RST_VAL
// (all ones = negated for low-true lines).
module qbus_sync #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Two-stage capture of the asynchronous inputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/qbus_dma_master.sv
// Qbus DMA master: arbitrates for the bus, runs single-word DATI/DATO
// cycles in bursts of up to MAX_BURST per BSACK tenure and reports
// data/status back to the register file.
module qbus_dma_master
  import qbus_pkg::*;
#(
  parameter int T_ASETUP  = T_ASETUP_D,
  parameter int T_AHOLD   = T_AHOLD_D,
  parameter int T_DSETUP  = T_DSETUP_D,
  parameter int T_TIMEOUT = T_TIMEOUT_D,
  parameter int MAX_BURST = MAX_BURST_D
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [21:0] cmd_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_error,
  output logic        busy,
  input  logic        BDMGIf,
  input  logic        BRPLYf,
  input  logic        BSYNCf,
  input  logic        BINITf,
  input  logic [21:0] BDALf_IN,
  output logic        BDMRg,
  output logic        BSACKg,
  output logic        BSYNCg,
  output logic        BDINg,
  output logic        BDOUTg,
  output logic        BWTBTg,
  output logic        BBS7g,
  output logic        BDMGOg,
  output logic [21:0] BDAL_OUT,
  output logic        BDAL_OE,
  output logic        Outbound
);

  localparam int BW = $clog2(MAX_BURST + 1);

  // Only the data half of BDAL is ever read back.
  logic [19:0] sync_q;
  logic        grant, rply, bus_sync, binit;
  logic [15:0] bdal_in;

  qbus_sync #(.W(20)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     ({BDMGIf, BRPLYf, BSYNCf, BINITf, BDALf_IN[15:0]}),
    .q     (sync_q)
  );

  assign grant    = ~sync_q[19];
  assign rply     = ~sync_q[18];
  assign bus_sync = ~sync_q[17];
  assign binit    = ~sync_q[16];
  assign bdal_in  = ~sync_q[15:0];

  logic unused_bits;
  assign unused_bits = ^{BDALf_IN[21:16], cmd_addr[0]};

  qbus_state_e      state, state_nx;
  qbus_drv_t        drv, drv_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [BW-1:0]    burst, burst_nx;
  logic [15:0]      rdat, rdat_nx;
  logic             cmd_wr;
  logic [15:0]      cmd_wd;
  logic             take, tmo;

  // Next state and next drive set; the single counter is reloaded
  // whenever the state changes and counts down otherwise.
  always_comb begin
    state_nx           = state;
    drv_nx             = drv;
    drv_nx.rsp_valid   = 1'b0;
    drv_nx.rsp_error   = 1'b0;
    cnt_nx             = (cnt != '0) ? cnt - CNT_W'(1) : cnt;
    burst_nx           = burst;
    rdat_nx            = rdat;
    take               = 1'b0;
    tmo                = 1'b0;
    unique case (state)
      S_IDLE: if (cmd_valid) begin
        state_nx    = S_REQ;
        drv_nx.bdmr = 1'b1;
      end
      S_REQ: if (grant && !bus_sync && !rply) begin
        state_nx     = S_ACK;
        drv_nx.bdmr  = 1'b0;
        drv_nx.bsack = 1'b1;
      end
      S_ACK: if (cmd_valid) begin
        take     = 1'b1;
        state_nx = S_ADDR;
      end else begin
        state_nx     = S_RELEASE;
        drv_nx.bsack = 1'b0;
      end
      S_ADDR: if (cnt == '0) begin
        state_nx     = S_SYNC;
        drv_nx.bsync = 1'b1;
      end
      S_SYNC: if (cnt == '0) begin
        drv_nx.bbs7 = 1'b0;
        if (cmd_wr) begin
          state_nx     = S_WDATA;
          drv_nx.bdal  = {6'b0, cmd_wd};
          drv_nx.bwtbt = 1'b0;
        end else begin
          state_nx       = S_RDIN;
          drv_nx.bdal_oe = 1'b0;
          drv_nx.bdal    = '0;
          drv_nx.bdin    = 1'b1;
        end
      end
      S_WDATA: if (cnt == '0) begin
        state_nx     = S_WRPLY;
        drv_nx.bdout = 1'b1;
      end
      S_RDIN: begin
        if (rply)            state_nx = S_RDSK;
        else if (cnt == '0)  tmo      = 1'b1;
      end
      // One extra clock after BRPLY so the data lines have settled.
      S_RDSK: begin
        rdat_nx     = bdal_in;
        drv_nx.bdin = 1'b0;
        state_nx    = S_NRPLY;
      end
      S_WRPLY: begin
        if (rply) begin
          drv_nx.bdout = 1'b0;
          state_nx     = S_NRPLY;
        end else if (cnt == '0) begin
          tmo = 1'b1;
        end
      end
      S_NRPLY: begin
        if (!rply) begin
          state_nx         = S_ENDC;
          drv_nx.bsync     = 1'b0;
          drv_nx.bdal_oe   = 1'b0;
          drv_nx.bdal      = '0;
          drv_nx.rsp_valid = 1'b1;
          drv_nx.rsp_rdata = cmd_wr ? 16'h0 : rdat;
          burst_nx         = burst + BW'(1);
        end else if (cnt == '0) begin
          tmo = 1'b1;
        end
      end
      S_ENDC: if (cmd_valid && burst < BW'(MAX_BURST)) begin
        take     = 1'b1;
        state_nx = S_ADDR;
      end else begin
        state_nx     = S_RELEASE;
        drv_nx.bsack = 1'b0;
      end
      S_RELEASE: begin
        burst_nx = '0;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase

    // Device never answered: free the bus and report an error.
    if (tmo) begin
      state_nx         = S_RELEASE;
      drv_nx.bsync     = 1'b0;
      drv_nx.bdin      = 1'b0;
      drv_nx.bdout     = 1'b0;
      drv_nx.bdal_oe   = 1'b0;
      drv_nx.bdal      = '0;
      drv_nx.bwtbt     = 1'b0;
      drv_nx.bsack     = 1'b0;
      drv_nx.rsp_valid = 1'b1;
      drv_nx.rsp_error = 1'b1;
      drv_nx.rsp_rdata = '0;
    end

    // Accepting a command starts its address phase on the same edge.
    if (take) begin
      drv_nx.bdal_oe = 1'b1;
      drv_nx.bdal    = {cmd_addr[21:1], 1'b0};
      drv_nx.bwtbt   = cmd_write;
      drv_nx.bbs7    = is_iopage(cmd_addr);
    end

    // Pass the grant down the chain only when we are not asking for it.
    drv_nx.bdmgo = grant && (state == S_IDLE) && !cmd_valid;

    if (state_nx != state) begin
      case (state_nx)
        S_ADDR:                  cnt_nx = CNT_W'(T_ASETUP - 1);
        S_SYNC:                  cnt_nx = CNT_W'(T_AHOLD - 1);
        S_WDATA:                 cnt_nx = CNT_W'(T_DSETUP - 1);
        S_RDIN, S_WRPLY, S_NRPLY: cnt_nx = CNT_W'(T_TIMEOUT - 1);
        default:                 cnt_nx = '0;
      endcase
    end

    // Bus init drops every line at once and discards the cycle.
    if (binit) begin
      state_nx = S_IDLE;
      drv_nx   = '0;
      cnt_nx   = '0;
      burst_nx = '0;
      take     = 1'b0;
    end
  end

  // State, drive and command registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      drv    <= '0;
      cnt    <= '0;
      burst  <= '0;
      rdat   <= '0;
      cmd_wr <= 1'b0;
      cmd_wd <= '0;
    end else begin
      state <= state_nx;
      drv   <= drv_nx;
      cnt   <= cnt_nx;
      burst <= burst_nx;
      rdat  <= rdat_nx;
      if (take) begin
        cmd_wr <= cmd_write;
        cmd_wd <= cmd_wdata;
      end
    end
  end

  assign cmd_ready = take;
  assign busy      = (state != S_IDLE);
  assign rsp_valid = drv.rsp_valid;
  assign rsp_error = drv.rsp_error;
  assign rsp_rdata = drv.rsp_rdata;
  assign BDMRg     = drv.bdmr;
  assign BSACKg    = drv.bsack;
  assign BSYNCg    = drv.bsync;
  assign BDINg     = drv.bdin;
  assign BDOUTg    = drv.bdout;
  assign BWTBTg    = drv.bwtbt;
  assign BBS7g     = drv.bbs7;
  assign BDMGOg    = drv.bdmgo;
  assign BDAL_OUT  = drv.bdal;
  assign BDAL_OE   = drv.bdal_oe;
  assign Outbound  = drv.bdal_oe;

endmodule

// File: tb/tb_qbus_dma_master.sv
// Directed bench for qbus_dma_master with a simple arbiter and slave.
module tb_qbus_dma_master;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [21:0] cmd_addr = '0;
  logic [15:0] cmd_wdata = '0;
  logic        cmd_ready, rsp_valid, rsp_error, busy;
  logic [15:0] rsp_rdata;
  logic        BDMGIf, BRPLYf, BSYNCf;
  logic        BINITf = 1'b1;
  logic [21:0] BDALf_IN;
  logic        BDMRg, BSACKg, BSYNCg, BDINg, BDOUTg, BWTBTg, BBS7g, BDMGOg;
  logic [21:0] BDAL_OUT;
  logic        BDAL_OE, Outbound;

  qbus_dma_master dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error), .busy(busy),
    .BDMGIf(BDMGIf), .BRPLYf(BRPLYf), .BSYNCf(BSYNCf), .BINITf(BINITf), .BDALf_IN(BDALf_IN),
    .BDMRg(BDMRg), .BSACKg(BSACKg), .BSYNCg(BSYNCg), .BDINg(BDINg), .BDOUTg(BDOUTg),
    .BWTBTg(BWTBTg), .BBS7g(BBS7g), .BDMGOg(BDMGOg),
    .BDAL_OUT(BDAL_OUT), .BDAL_OE(BDAL_OE), .Outbound(Outbound)
  );

  always #5 clock = ~clock;

  // arbiter + slave device
  logic        gnt = 1'b0, grant_force = 1'b0;
  logic        dev_en = 1'b1, dev_rply = 1'b0;
  logic [15:0] dev_rdata = '0;
  int          dev_cnt = 0;
  int          dev_dly = 30;

  always @(posedge clock) gnt <= BDMRg && !BSACKg;

  always @(posedge clock) begin
    if (!(BDINg || BDOUTg)) begin
      dev_cnt  <= 0;
      dev_rply <= 1'b0;
    end else if (dev_en && !dev_rply) begin
      if (dev_cnt >= dev_dly) dev_rply <= 1'b1;
      else                    dev_cnt  <= dev_cnt + 1;
    end
  end

  assign BDMGIf   = ~(gnt | grant_force);
  assign BRPLYf   = ~dev_rply;
  assign BSYNCf   = ~BSYNCg;
  assign BDALf_IN = ~(BDAL_OE ? BDAL_OUT : (dev_rply ? {6'b0, dev_rdata} : 22'h0));

  // monitors
  int          cyc = 0, acc_n = 0, rsp_n = 0, sack_n = 0, viol_sync = 0, viol_dio = 0;
  int          t_sync = 0, t_oe = 0, t_wtf = 0, t_dout = 0, t_din = 0, t_rsp = 0;
  logic        p_sync = 0, p_dout = 0, p_din = 0, p_oe = 0, p_wtbt = 0, p_sack = 0;
  logic [21:0] addr_at_sync = '0;
  logic        bbs7_at_sync = 0, wtbt_at_sync = 0, bbs7_at_dout = 0;
  logic [15:0] wd_at_dout = '0, last_rdata = '0;
  logic        last_err = 0, last_bsync = 0, last_bdin = 0, last_bsack = 0;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (cmd_valid && cmd_ready) acc_n <= acc_n + 1;
  end

  always @(negedge clock) begin
    p_sync <= BSYNCg; p_dout <= BDOUTg; p_din <= BDINg;
    p_oe <= BDAL_OE; p_wtbt <= BWTBTg; p_sack <= BSACKg;
    if (BSYNCg && !p_sync) begin
      t_sync <= cyc; addr_at_sync <= BDAL_OUT;
      bbs7_at_sync <= BBS7g; wtbt_at_sync <= BWTBTg;
      if (!BDAL_OE) viol_sync <= viol_sync + 1;
    end
    if (BDAL_OE && !p_oe) t_oe <= cyc;
    if (!BWTBTg && p_wtbt) t_wtf <= cyc;
    if (BDOUTg && !p_dout) begin
      t_dout <= cyc; bbs7_at_dout <= BBS7g; wd_at_dout <= BDAL_OUT[15:0];
    end
    if (BDINg && !p_din) t_din <= cyc;
    if (BSACKg && !p_sack) sack_n <= sack_n + 1;
    if (BDINg && BDOUTg) viol_dio <= viol_dio + 1;
    if (rsp_valid) begin
      rsp_n <= rsp_n + 1; t_rsp <= cyc;
      last_rdata <= rsp_rdata; last_err <= rsp_error;
      last_bsync <= BSYNCg; last_bdin <= BDINg; last_bsack <= BSACKg;
    end
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic put_cmd(input logic w, input logic [21:0] a, input logic [15:0] d);
    int s;
    s = acc_n;
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    for (int i = 0; i < 300 && acc_n == s; i++) @(negedge clock);
    chk("accept", 64'(acc_n - s), 64'd1);
  endtask

  task automatic wait_rsp(input string tag, input int s, input int n, input int budget);
    for (int i = 0; i < budget && (rsp_n - s) < n; i++) @(negedge clock);
    @(negedge clock);
    chk(tag, 64'(rsp_n - s), 64'(n));
  endtask

  function automatic logic [63:0] outs();
    return {12'h0, BDMRg, BSACKg, BSYNCg, BDINg, BDOUTg, BWTBTg, BBS7g, BDMGOg,
            BDAL_OE, Outbound, rsp_valid, rsp_error, busy, cmd_ready, BDAL_OUT, rsp_rdata};
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s, d;
    repeat (3) @(negedge clock);
    chk("reset_outs", outs(), 64'h0);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("idle_busy", {63'h0, busy}, 64'h0);

    // grant relay while idle, then grant taken for own command
    grant_force = 1'b1;
    repeat (4) @(negedge clock);
    chk("gnt_relay", {63'h0, BDMGOg}, 64'h1);
    grant_force = 1'b0;
    repeat (4) @(negedge clock);
    chk("gnt_drop", {63'h0, BDMGOg}, 64'h0);
    grant_force = 1'b1;
    repeat (4) @(negedge clock);
    dev_rdata = 16'h1234;
    s = rsp_n;
    cmd_write = 1'b0; cmd_addr = 22'o100; cmd_valid = 1'b1;
    repeat (2) @(negedge clock);
    chk("gnt_bdmgo", {63'h0, BDMGOg}, 64'h0);
    chk("gnt_bsack", {63'h0, BSACKg}, 64'h1);
    put_cmd(1'b0, 22'o100, 16'h0);
    cmd_valid = 1'b0;
    wait_rsp("gnt_rsp", s, 1, 300);
    chk("gnt_rdata", 64'(last_rdata), 64'h1234);
    grant_force = 1'b0;
    repeat (5) @(negedge clock);

    // DATI
    dev_rdata = 16'o123456;
    s = rsp_n;
    put_cmd(1'b0, 22'o00001000, 16'h0);
    cmd_valid = 1'b0;
    wait_rsp("dati_rsp", s, 1, 300);
    chk("dati_rdata", 64'(last_rdata), 64'(16'o123456));
    chk("dati_err", {63'h0, last_err}, 64'h0);
    chk("dati_addr", 64'(addr_at_sync), 64'(22'o00001000));
    chk("dati_asetup", 64'(t_sync - t_oe), 64'd15);
    chk("dati_bbs7", {63'h0, bbs7_at_sync}, 64'h0);
    repeat (5) @(negedge clock);

    // DATO to the I/O page
    s = rsp_n;
    put_cmd(1'b1, 22'o17772152, 16'hA5A5);
    cmd_valid = 1'b0;
    wait_rsp("dato_rsp", s, 1, 300);
    chk("dato_err", {63'h0, last_err}, 64'h0);
    chk("dato_addr", 64'(addr_at_sync), 64'(22'o17772152));
    chk("dato_wtbt", {63'h0, wtbt_at_sync}, 64'h1);
    chk("dato_bbs7_a", {63'h0, bbs7_at_sync}, 64'h1);
    chk("dato_bbs7_d", {63'h0, bbs7_at_dout}, 64'h0);
    chk("dato_wdata", 64'(wd_at_dout), 64'hA5A5);
    chk("dato_dsetup", 64'(t_dout - t_wtf), 64'd10);
    repeat (5) @(negedge clock);

    // six back-to-back reads, odd addresses
    s = rsp_n;
    d = sack_n;
    for (int i = 0; i < 6; i++) put_cmd(1'b0, 22'o2001 + 22'(2 * i), 16'h0);
    cmd_valid = 1'b0;
    wait_rsp("burst_rsp", s, 6, 2000);
    chk("burst_tenures", 64'(sack_n - d), 64'd2);
    chk("burst_addr0", 64'(addr_at_sync), 64'(22'o2012));
    repeat (5) @(negedge clock);

    // no reply: timeout
    dev_en = 1'b0;
    s = rsp_n;
    put_cmd(1'b0, 22'o4000, 16'h0);
    cmd_valid = 1'b0;
    wait_rsp("to_rsp", s, 1, 1300);
    chk("to_err", {63'h0, last_err}, 64'h1);
    chk("to_rdata", 64'(last_rdata), 64'h0);
    chk("to_bsync", {63'h0, last_bsync}, 64'h0);
    chk("to_bdin", {63'h0, last_bdin}, 64'h0);
    chk("to_bsack", {63'h0, last_bsack}, 64'h0);
    d = t_rsp - t_din;
    chk("to_latency", {63'h0, (d >= 1000 && d <= 1003)}, 64'h1);
    repeat (5) @(negedge clock);

    // BINIT during RDIN
    s = rsp_n;
    put_cmd(1'b0, 22'o6000, 16'h0);
    cmd_valid = 1'b0;
    for (int i = 0; i < 200 && !BDINg; i++) @(negedge clock);
    chk("binit_rdin", {63'h0, BDINg}, 64'h1);
    BINITf = 1'b0;
    repeat (3) @(negedge clock);
    chk("binit_outs", outs(), 64'h0);
    repeat (5) @(negedge clock);
    BINITf = 1'b1;
    repeat (4) @(negedge clock);
    chk("binit_norsp", 64'(rsp_n - s), 64'h0);
    dev_en = 1'b1;
    dev_rdata = 16'h5A3C;
    put_cmd(1'b0, 22'o6000, 16'h0);
    cmd_valid = 1'b0;
    wait_rsp("binit_next", s, 1, 300);
    chk("binit_rdata", 64'(last_rdata), 64'h5A3C);
    chk("binit_err", {63'h0, last_err}, 64'h0);

    chk("invariants", 64'(viol_sync + viol_dio), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
